// File: rtl/imem_boot_ctrl_if.sv
// Loader handshake and instruction-memory port bundle for imem_boot_ctrl.
// The controller side takes the master modport; the loader/memory side takes slave.
interface imem_boot_ctrl_if;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_raddr;
  logic [31:0] mem_rdata;

  modport master (
    input  ld_valid, ld_data, mem_rdata,
    output ld_ready, mem_we, mem_waddr, mem_wdata, mem_raddr
  );

  modport slave (
    output ld_valid, ld_data, mem_rdata,
    input  ld_ready, mem_we, mem_waddr, mem_wdata, mem_raddr
  );
endinterface

// File: rtl/imem_boot_ctrl.sv
// Boot controller: streams a program into instruction memory, holds the CPU in reset
// while loading, then serves fetches with NOP substitution on faulting addresses.
module imem_boot_ctrl #(
  parameter int unsigned DEPTH = 256,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   boot_start,
  input  logic [8:0]             boot_len,
  input  logic [31:0]            cpu_pc,
  output logic [31:0]            cpu_instr,
  output logic                   cpu_rst,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  imem_boot_ctrl_if.master       bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;

  localparam logic [8:0] MaxLen = 9'(DEPTH);

  logic [1:0] state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic [8:0] len_q, len_d;
  logic       err_q, err_d;
  logic       done_q, done_d;

  logic       ld_ready;
  logic       hs;
  logic       fault;
  logic [8:0] start_len;

  // Ready is gated by rst so an in-flight word is never written during reset.
  assign ld_ready  = (state_q == StLoad) && !rst;
  assign hs        = bus.ld_valid && ld_ready;
  assign fault     = (state_q == StRun) && ((cpu_pc[1:0] != 2'b00) || (cpu_pc[31:10] != '0));
  assign start_len = (boot_len > MaxLen) ? MaxLen : boot_len;

  assign bus.ld_ready  = ld_ready;
  assign bus.mem_we    = hs;
  assign bus.mem_waddr = cnt_q[7:0];
  assign bus.mem_wdata = bus.ld_data;
  assign bus.mem_raddr = cpu_pc[9:2];

  assign cpu_instr = ((state_q == StRun) && !fault) ? bus.mem_rdata : NOP;
  assign cpu_rst   = (state_q != StRun);
  assign busy      = (state_q == StLoad);
  assign done      = done_q;
  assign err       = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    err_d   = err_q;
    done_d  = 1'b0;
    if (boot_start && (state_q != StLoad)) begin
      // A restart clears err even if this cycle also faults.
      len_d = start_len;
      cnt_d = '0;
      err_d = 1'b0;
      if (start_len == '0) begin
        state_d = StRun;
        done_d  = 1'b1;
      end else begin
        state_d = StLoad;
      end
    end else if (hs) begin
      cnt_d = cnt_q + 9'd1;
      if (cnt_q == len_q - 9'd1) begin
        state_d = StRun;
        done_d  = 1'b1;
      end
    end else if (fault) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Randomized self-checking bench for imem_boot_ctrl against a transaction-level model
// (words remaining, next address, running/loading flags) plus pinned directed scenarios.
module tb_imem_boot_ctrl;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        boot_start;
  logic [8:0]  boot_len;
  logic [31:0] cpu_pc;
  logic [31:0] cpu_instr;
  logic        cpu_rst, busy, done, err;

  always #5 clk = ~clk;

  imem_boot_ctrl_if bus ();

  imem_boot_ctrl #(
    .DEPTH (256),
    .NOP   (NOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .boot_start (boot_start),
    .boot_len   (boot_len),
    .cpu_pc     (cpu_pc),
    .cpu_instr  (cpu_instr),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .bus        (bus)
  );

  // Memory seen by the DUT (written only by the DUT) and the model's own copy.
  bit [31:0] tb_mem [256];
  bit [31:0] ref_mem[256];
  int        wr_cnt = 0;
  int        wr0_cnt = 0;
  int        last_waddr = -1;

  assign bus.mem_rdata = tb_mem[bus.mem_raddr];

  always @(posedge clk) begin
    if (bus.mem_we) begin
      tb_mem[bus.mem_waddr] <= bus.mem_wdata;
      wr_cnt     = wr_cnt + 1;
      last_waddr = int'(bus.mem_waddr);
      if (bus.mem_waddr == 8'd0) wr0_cnt = wr0_cnt + 1;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  // Model: loading/running flags, words still to load, next load address.
  bit m_loading = 0, m_running = 0, m_err = 0, m_done = 0;
  int m_left = 0, m_addr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Check every output at the falling edge, then advance the model across the rising edge.
  task automatic cycle();
    bit          exp_ready, exp_we, flt;
    logic [31:0] exp_instr;
    int          l;
    @(negedge clk);
    exp_ready = m_loading && !rst;
    exp_we    = exp_ready && bus.ld_valid;
    flt       = m_running && ((cpu_pc % 4) != 0 || cpu_pc >= 32'd1024);
    exp_instr = (m_running && !flt) ? ref_mem[(cpu_pc / 4) % 256] : NOP;
    chk("ld_ready", 32'(bus.ld_ready), 32'(exp_ready));
    chk("mem_we", 32'(bus.mem_we), 32'(exp_we));
    if (exp_we) begin
      chk("mem_waddr", 32'(bus.mem_waddr), 32'(m_addr));
      chk("mem_wdata", bus.mem_wdata, bus.ld_data);
    end
    chk("mem_raddr", 32'(bus.mem_raddr), (cpu_pc / 4) % 256);
    chk("cpu_instr", cpu_instr, exp_instr);
    chk("cpu_rst", 32'(cpu_rst), 32'(!m_running));
    chk("busy", 32'(busy), 32'(m_loading));
    chk("done", 32'(done), 32'(m_done));
    chk("err", 32'(err), 32'(m_err));

    if (rst) begin
      m_loading = 0; m_running = 0; m_err = 0; m_done = 0; m_left = 0; m_addr = 0;
    end else begin
      m_done = 0;
      if (boot_start && !m_loading) begin
        l = (int'(boot_len) > 256) ? 256 : int'(boot_len);
        m_err = 0;
        m_addr = 0;
        if (l == 0) begin
          m_running = 1; m_done = 1;
        end else begin
          m_loading = 1; m_running = 0; m_left = l;
        end
      end else if (m_loading && bus.ld_valid) begin
        ref_mem[m_addr] = bus.ld_data;
        m_addr++;
        m_left--;
        if (m_left == 0) begin
          m_loading = 0; m_running = 1; m_done = 1;
        end
      end else if (flt) begin
        m_err = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  int base, base0;

  initial begin
    rst = 1'b1; boot_start = 1'b0; boot_len = '0; cpu_pc = '0;
    bus.ld_valid = 1'b1; bus.ld_data = 32'hDEAD_BEEF;
    cycle(); cycle();
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_instr", cpu_instr, NOP);
    chk("rst_we", 32'(bus.mem_we), 32'd0);

    // Three-word load with ld_valid held high.
    rst = 1'b0; bus.ld_valid = 1'b0;
    base = wr_cnt;
    boot_start = 1'b1; boot_len = 9'd3; cycle();
    boot_start = 1'b0; bus.ld_valid = 1'b1;
    bus.ld_data = 32'hAAAA_0001; cycle();
    bus.ld_data = 32'hBBBB_0002; cycle();
    bus.ld_data = 32'hCCCC_0003; cycle();
    bus.ld_valid = 1'b0;
    chk("s1_done", 32'(done), 32'd1);
    chk("s1_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("s1_writes", 32'(wr_cnt - base), 32'd3);
    chk("s1_mem2", tb_mem[2], 32'hCCCC_0003);
    cycle();
    chk("s1_done_gone", 32'(done), 32'd0);

    // Two-word load with a gap in ld_valid.
    base = wr_cnt;
    boot_start = 1'b1; boot_len = 9'd2; cycle();
    boot_start = 1'b0;
    bus.ld_valid = 1'b1; bus.ld_data = 32'h1111_1111; cycle();
    bus.ld_valid = 1'b0; bus.ld_data = 32'h2222_2222; cycle();
    chk("s2_ready_held", 32'(bus.ld_ready), 32'd1);
    bus.ld_valid = 1'b1; bus.ld_data = 32'h3333_3333; cycle();
    bus.ld_valid = 1'b0;
    chk("s2_writes", 32'(wr_cnt - base), 32'd2);
    chk("s2_mem1", tb_mem[1], 32'h3333_3333);

    // Oversized request caps at 256 words with no wrap to address 0.
    base = wr_cnt; base0 = wr0_cnt;
    boot_start = 1'b1; boot_len = 9'd300; cycle();
    boot_start = 1'b0; bus.ld_valid = 1'b1;
    for (int i = 0; i < 260; i++) begin
      bus.ld_data = 32'hC0DE_0000 + 32'(i);
      cycle();
    end
    bus.ld_valid = 1'b0;
    chk("s3_writes", 32'(wr_cnt - base), 32'd256);
    chk("s3_addr0_once", 32'(wr0_cnt - base0), 32'd1);
    chk("s3_last_addr", 32'(last_waddr), 32'd255);

    // Fetch path and sticky fault flag.
    cpu_pc = 32'h8; #1;
    chk("s4_raddr", 32'(bus.mem_raddr), 32'd2);
    chk("s4_instr", cpu_instr, 32'hC0DE_0002);
    cycle();
    cpu_pc = 32'h6; #1;
    chk("s4_fault_nop", cpu_instr, NOP);
    cycle();
    chk("s4_err_set", 32'(err), 32'd1);
    cpu_pc = 32'h4; cycle();
    chk("s4_err_sticky", 32'(err), 32'd1);
    cpu_pc = 32'h6; boot_start = 1'b1; boot_len = 9'd0; cycle();
    boot_start = 1'b0; cpu_pc = 32'h0;
    chk("s4_err_clear", 32'(err), 32'd0);
    chk("s4_len0_done", 32'(done), 32'd1);

    // boot_start during LOAD is ignored.
    base = wr_cnt;
    boot_start = 1'b1; boot_len = 9'd5; cycle();
    boot_len = 9'd1; bus.ld_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.ld_data = $urandom; cycle();
    end
    boot_start = 1'b0; bus.ld_valid = 1'b0;
    chk("s5_writes", 32'(wr_cnt - base), 32'd5);
    chk("s5_done", 32'(done), 32'd1);

    // Reset mid-load aborts without writing or pulsing done.
    boot_start = 1'b1; boot_len = 9'd4; cycle();
    boot_start = 1'b0; bus.ld_valid = 1'b1;
    cycle(); cycle();
    rst = 1'b1; #1;
    chk("s6_we_gated", 32'(bus.mem_we), 32'd0);
    cycle();
    rst = 1'b0; bus.ld_valid = 1'b0;
    chk("s6_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("s6_busy", 32'(busy), 32'd0);
    cycle();
    chk("s6_no_done", 32'(done), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      rst          = ($urandom_range(0, 199) == 0);
      boot_start   = ($urandom_range(0, 39) == 0);
      boot_len     = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(250, 511))
                                                 : 9'($urandom_range(0, 12));
      bus.ld_valid = $urandom_range(0, 1) == 1;
      bus.ld_data  = $urandom;
      case ($urandom_range(0, 3))
        0:       cpu_pc = $urandom;
        1:       cpu_pc = 32'($urandom_range(0, 1023));
        default: cpu_pc = 32'($urandom_range(0, 255)) * 4;
      endcase
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_boot_ctrl.md
IMEM_BOOT_CTRL -- requirements
Module: imem_boot_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, 256, instruction memory depth in 32-bit words (fixed; 8-bit word address).
REQ-002 SHALL have parameter NOP, 32'h00000013, instruction supplied to CPU while it is not running or on a faulting fetch.
REQ-003 SHALL use one clock and a synchronous, active-high reset, with ports:
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 boot_start  in  1  single-cycle request to (re)load program memory.
REQ-007 boot_len  in  9  number of words to load, sampled with boot_start.
REQ-008 ld_valid  in  1  loader word valid.
REQ-009 ld_data  in  32  loader word.
REQ-010 ld_ready  out  1  controller accepts loader word.
REQ-011 mem_we  out  1  instruction memory write enable.
REQ-012 mem_waddr  out  8  instruction memory write word address.
REQ-013 mem_wdata  out  32  instruction memory write data.
REQ-014 cpu_pc  in  32  CPU fetch byte address.
REQ-015 mem_raddr  out  8  instruction memory read word address.
REQ-016 mem_rdata  in  32  instruction memory read data (combinational).
REQ-017 cpu_instr  out  32  instruction delivered to CPU.
REQ-018 cpu_rst  out  1  holds CPU in reset.
REQ-019 busy  out  1  load in progress.
REQ-020 done  out  1  one-cycle pulse, load complete.
REQ-021 err  out  1  sticky fetch-fault flag.

Function
REQ-022 SHALL implement states IDLE, LOAD, RUN; reset state IDLE.
REQ-023 IDLE: cpu_rst=1, ld_ready=0, mem_we=0, busy=0, cpu_instr=NOP.
REQ-024 boot_start in IDLE or RUN: latch len = min(boot_len, 256), clear word counter cnt to 0, clear err; next state LOAD, or RUN with done pulse if len==0.
REQ-025 boot_start while in LOAD SHALL be ignored (len, cnt unchanged).
REQ-026 LOAD: cpu_rst=1, busy=1, ld_ready=1, cpu_instr=NOP.
REQ-027 Handshake = ld_valid && ld_ready; in the same cycle mem_we=1, mem_waddr=cnt[7:0], mem_wdata=ld_data (combinational, no added latency); cnt increments at the edge.
REQ-028 mem_we SHALL be 0 in every cycle without a handshake; ld_valid without ld_ready SHALL not write.
REQ-029 Handshake with cnt==len-1: next state RUN; done=1 for exactly the first RUN cycle.
REQ-030 cnt SHALL be 9 bits; 256-word load writes addresses 0..255 then exits, with no wrap-write to address 0.
REQ-031 RUN: cpu_rst=0, busy=0, ld_ready=0, mem_raddr=cpu_pc[9:2], cpu_instr=mem_rdata, combinational.
REQ-032 mem_raddr SHALL equal cpu_pc[9:2] in all states.
REQ-033 RUN fault = cpu_pc[1:0]!=0 or cpu_pc[31:10]!=0; in a fault cycle cpu_instr=NOP and err sets at the edge, remains 1 until rst or boot_start.
REQ-034 boot_start in RUN SHALL reassert cpu_rst from the next cycle (reload; CPU restarts from reset after completion).
REQ-035 boot_start and a fault in the same RUN cycle: err cleared (boot_start wins).

Reset
REQ-036 rst=1 SHALL force mem_we=0 and ld_ready=0 in the same cycle (gated), and at the edge: state IDLE, cnt=0, len=0, err=0, done=0.
REQ-037 After reset: cpu_rst=1, busy=0, cpu_instr=NOP until a load completes.
REQ-038 rst during LOAD aborts the load; words already written remain in memory; no done pulse.

Verification
REQ-039 Reset, boot_start with boot_len=3, ld_valid held 1 with data A,B,C -> writes addr 0,1,2 on three consecutive cycles, done pulse next cycle, cpu_rst=0.
REQ-040 boot_len=2, ld_valid toggling 1,0,1 -> only two writes (addr 0,1), no write in ld_valid=0 cycle, ld_ready stays 1 through LOAD.
REQ-041 boot_len=300 -> exactly 256 writes, addr 0..255, last write then RUN; no write to addr 0 after 255.
REQ-042 RUN with cpu_pc=0x8 -> mem_raddr=2, cpu_instr=mem_rdata; cpu_pc=0x6 -> cpu_instr=NOP, err=1 next cycle, stays 1; boot_start -> err=0.
REQ-043 boot_len=0 -> RUN next cycle with done=1, no writes; boot_start during LOAD ignored.
REQ-044 rst asserted with ld_valid=1 mid-LOAD -> mem_we=0 that cycle, IDLE next, no done, cpu_rst=1.
